// File: rtl/opsel_pkg.sv
// -----------------------------------------------------------------------------
// opsel_pkg
// Shared definitions for the opcode capture unit:
//   - FSM state encoding (IDLE, FILTER, PRESENT, RELEASE)
//   - is_onehot():     true when exactly one bit of a request pattern is set
//   - index_to_code(): maps a request-line index to its opcode code
// Request lines are handled zero-extended to MAX_OPS bits inside the helpers.
// The optional feature macro OPSEL_PRIORITY_EN is consumed by opsel_encoder
// and opsel_capture, not by this package.
// -----------------------------------------------------------------------------
package opsel_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FILTER  = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    // Widest request vector the helper functions accept.
    localparam int MAX_OPS = 32;

    function automatic logic is_onehot(input logic [MAX_OPS-1:0] vec);
        // Clearing the lowest set bit leaves zero only for a single-bit value.
        return (vec != '0) && ((vec & (vec - MAX_OPS'(1))) == '0);
    endfunction

    // Line i maps to code n_ops-i: the top line is opcode 1, line 0 the last.
    function automatic logic [MAX_OPS-1:0] index_to_code(input int n_ops, input int idx);
        return MAX_OPS'(n_ops - idx);
    endfunction

endpackage

// File: rtl/opsel_encoder.sv
// -----------------------------------------------------------------------------
// opsel_encoder
// Combinational encoder for a captured request pattern.
// Ports:
//   pat       in  N_OPS   captured request pattern
//   code      out CODE_W  encoded opcode (0 = none / unresolved multi-hot)
//   onehot    out 1       exactly one line set
//   multihot  out 1       two or more lines set
// Build option: OPSEL_PRIORITY_EN
//   undefined - a multi-hot pattern encodes to 0
//   defined   - a multi-hot pattern encodes to its highest-index set line
// -----------------------------------------------------------------------------
module opsel_encoder
    import opsel_pkg::*;
#(
    parameter int N_OPS  = 6,
    parameter int CODE_W = 3
) (
    input  logic [N_OPS-1:0]  pat,
    output logic [CODE_W-1:0] code,
    output logic              onehot,
    output logic              multihot
);

    logic [CODE_W-1:0]  bit_code [N_OPS];
    logic [CODE_W-1:0]  prio_code;
    logic [MAX_OPS-1:0] pat_ext;

    // Constant code for every request line.
    genvar gi;
    generate
        for (gi = 0; gi < N_OPS; gi++) begin : g_code
            localparam logic [MAX_OPS-1:0] FULL_CODE = index_to_code(N_OPS, gi);
            assign bit_code[gi] = FULL_CODE[CODE_W-1:0];
        end
    endgenerate

    assign pat_ext = MAX_OPS'(pat);

    // Ascending scan: the last set line seen (highest index, lowest code) wins.
    always_comb begin
        prio_code = '0;
        for (int i = 0; i < N_OPS; i++) begin
            if (pat[i]) begin
                prio_code = bit_code[i];
            end
        end
    end

    assign onehot   = is_onehot(pat_ext);
    assign multihot = (pat != '0) && !onehot;

`ifdef OPSEL_PRIORITY_EN
    assign code = prio_code;
`else
    assign code = onehot ? prio_code : '0;
`endif

endmodule

// File: rtl/opsel_capture.sv
// -----------------------------------------------------------------------------
// opsel_capture
// Debounced one-hot opcode capture with a valid/ready output and a held
// "current opcode" register for the ALU. One transfer per press.
// Ports:
//   clk        in  1       rising-edge clock
//   reset_n    in  1       asynchronous active-low reset
//   op_req     in  N_OPS   request lines (bit N_OPS-1 = opcode 1)
//   out_ready  in  1       consumer accepts out_code
//   out_valid  out 1       out_code/out_err presented
//   out_code   out CODE_W  encoded opcode, 0 = none/invalid
//   out_err    out 1       presented pattern was multi-hot
//   cur_code   out CODE_W  last transferred non-error code
//   busy       out 1       FSM not idle
// Build option: OPSEL_PRIORITY_EN resolves multi-hot presses by priority
// instead of flagging them through out_err.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module opsel_capture
    import opsel_pkg::*;
#(
    parameter int N_OPS         = 6,
    parameter int CODE_W        = 3,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_OPS-1:0]  op_req,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    output logic              out_err,
    output logic [CODE_W-1:0] cur_code,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [1:0]        state_reg, state_next;
    logic [N_OPS-1:0]  pat_reg, pat_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              capture;
    logic              transfer;
    logic [CODE_W-1:0] enc_code;
    logic              enc_onehot;
    logic              enc_multihot;
    logic              err_eval;

    opsel_encoder #(
        .N_OPS  (N_OPS),
        .CODE_W (CODE_W)
    ) u_encoder (
        .pat      (pat_reg),
        .code     (enc_code),
        .onehot   (enc_onehot),
        .multihot (enc_multihot)
    );

`ifdef OPSEL_PRIORITY_EN
    assign err_eval = 1'b0;
`else
    assign err_eval = enc_multihot;
`endif

    always_comb begin
        state_next = state_reg;
        pat_next   = pat_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        transfer   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (op_req != '0) begin
                    pat_next   = op_req;
                    cnt_next   = '0;
                    state_next = FILTER;
                end
            end
            FILTER: begin
                if (op_req == '0) begin
                    state_next = IDLE;
                end else if (op_req != pat_reg) begin
                    // Any change restarts the stability window from this edge.
                    pat_next = op_req;
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    // pat_reg is never zero here; the guard only keeps an
                    // empty pattern from ever being presented.
                    if (enc_onehot || enc_multihot) begin
                        capture    = 1'b1;
                        state_next = PRESENT;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            PRESENT: begin
                // op_req is ignored while the code is on offer.
                if (out_ready) begin
                    transfer   = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (op_req == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = RELEASE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // Entering RELEASE means a line held through reset is never taken.
            state_reg <= RELEASE;
            pat_reg   <= '0;
            cnt_reg   <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_err   <= 1'b0;
            cur_code  <= '0;
            busy      <= 1'b1;
        end else begin
            state_reg <= state_next;
            pat_reg   <= pat_next;
            cnt_reg   <= cnt_next;
            // Registered from the next state so valid/busy track the FSM
            // without a combinational path from the inputs.
            out_valid <= (state_next == PRESENT);
            busy      <= (state_next != IDLE);
            if (capture) begin
                out_code <= enc_code;
                out_err  <= err_eval;
            end
            if (transfer && !out_err) begin
                cur_code <= out_code;
            end
        end
    end

endmodule

// File: tb/tb_opsel_capture.sv
// -----------------------------------------------------------------------------
// tb_opsel_capture
// Self-checking bench for opsel_capture: a default-parameter instance
// (6 lines, 4-cycle filter) and a wide instance (10 lines, 1-cycle filter).
// Expected codes come from a small model of the opcode mapping rules.
// Honours OPSEL_PRIORITY_EN when the bundle is built with it.
// -----------------------------------------------------------------------------
module tb_opsel_capture;

    localparam int N      = 6;
    localparam int STABLE = 4;
    localparam int NW     = 10;

    logic          clk;
    logic          reset_n;
    logic [N-1:0]  op_req;
    logic          out_ready;
    logic          out_valid;
    logic [2:0]    out_code;
    logic          out_err;
    logic [2:0]    cur_code;
    logic          busy;

    logic [NW-1:0] op_req_w;
    logic          out_ready_w;
    logic          out_valid_w;
    logic [3:0]    out_code_w;
    logic          out_err_w;
    logic [3:0]    cur_code_w;
    logic          busy_w;

    int pass_count  = 0;
    int check_count = 0;
    int model_cur   = 0;

    opsel_capture #(
        .N_OPS(N), .CODE_W(3), .STABLE_CYCLES(STABLE), .CNT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .op_req(op_req), .out_ready(out_ready),
        .out_valid(out_valid), .out_code(out_code), .out_err(out_err),
        .cur_code(cur_code), .busy(busy)
    );

    opsel_capture #(
        .N_OPS(NW), .CODE_W(4), .STABLE_CYCLES(1), .CNT_W(8)
    ) dut_w (
        .clk(clk), .reset_n(reset_n), .op_req(op_req_w), .out_ready(out_ready_w),
        .out_valid(out_valid_w), .out_code(out_code_w), .out_err(out_err_w),
        .cur_code(cur_code_w), .busy(busy_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int model_code(input logic [N-1:0] p);
        int hi;
        hi = -1;
        for (int i = 0; i < N; i++) if (p[i]) hi = i;
        if (hi < 0) return 0;
        if ($countones(p) == 1) return N - hi;
`ifdef OPSEL_PRIORITY_EN
        return N - hi;
`else
        return 0;
`endif
    endfunction

    function automatic logic model_err(input logic [N-1:0] p);
`ifdef OPSEL_PRIORITY_EN
        return 1'b0;
`else
        return $countones(p) > 1;
`endif
    endfunction

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(input logic [N-1:0] op, input logic rdy);
        op_req    = op;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic step_w(input logic [NW-1:0] op, input logic rdy);
        op_req_w    = op;
        out_ready_w = rdy;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset_n = 1'b0;
        step(6'b0, 1'b0);
        check_count++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_count++;
        check_count++; if (out_code !== 3'd0) $display("FAIL reset_code got %0d want 0", out_code); else pass_count++;
        check_count++; if (out_err !== 1'b0) $display("FAIL reset_err got %b want 0", out_err); else pass_count++;
        check_count++; if (cur_code !== 3'd0) $display("FAIL reset_cur got %0d want 0", cur_code); else pass_count++;
        check_count++; if (busy !== 1'b1) $display("FAIL reset_busy got %b want 1", busy); else pass_count++;
        step(6'b0, 1'b0);
        reset_n = 1'b1;
        step(6'b0, 1'b0);
        check_count++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy); else pass_count++;
        $display("test_reset done");
    endtask

    task automatic test_single_press;
        int pulses;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step(6'b100000, 1'b1);
            check_count++;
            if (out_valid !== (k == STABLE)) $display("FAIL single_valid k=%0d got %b want %b", k, out_valid, (k == STABLE));
            else pass_count++;
            if (out_valid) begin
                pulses++;
                check_count++; if (out_code !== 3'd1) $display("FAIL single_code got %0d want 1", out_code); else pass_count++;
                check_count++; if (out_err !== 1'b0) $display("FAIL single_err got %b want 0", out_err); else pass_count++;
            end
        end
        model_cur = 1;
        check_count++; if (cur_code !== 3'(model_cur)) $display("FAIL single_cur got %0d want %0d", cur_code, model_cur); else pass_count++;
        for (int k = 0; k < 3; k++) step(6'b0, 1'b1);
        check_count++; if (busy !== 1'b0) $display("FAIL single_idle got busy %b want 0", busy); else pass_count++;
        $display("test_single_press pulses=%0d", pulses);
    endtask

    task automatic test_bounce;
        logic [N-1:0] p;
        int pulses;
        pulses = 0;
        for (int k = 0; k < 11; k++) begin
            p = (k == 2) ? 6'b0 : 6'b000100;
            step(p, 1'b1);
            check_count++;
            if (out_valid !== (k == 3 + STABLE)) $display("FAIL bounce_valid k=%0d got %b want %b", k, out_valid, (k == 3 + STABLE));
            else pass_count++;
            if (out_valid) begin
                pulses++;
                check_count++; if (out_code !== 3'd4) $display("FAIL bounce_code got %0d want 4", out_code); else pass_count++;
            end
        end
        for (int k = 0; k < 3; k++) step(6'b0, 1'b1);
        model_cur = 4;
        check_count++; if (cur_code !== 3'(model_cur)) $display("FAIL bounce_cur got %0d want %0d", cur_code, model_cur); else pass_count++;
        $display("test_bounce pulses=%0d", pulses);
    endtask

    task automatic test_multihot;
        logic [N-1:0] p;
        p = 6'b100001;
        for (int k = 0; k < 8; k++) begin
            step(p, 1'b1);
            check_count++;
            if (out_valid !== (k == STABLE)) $display("FAIL multi_valid k=%0d got %b want %b", k, out_valid, (k == STABLE));
            else pass_count++;
            if (out_valid) begin
                check_count++; if (out_code !== 3'(model_code(p))) $display("FAIL multi_code got %0d want %0d", out_code, model_code(p)); else pass_count++;
                check_count++; if (out_err !== model_err(p)) $display("FAIL multi_err got %b want %b", out_err, model_err(p)); else pass_count++;
            end
        end
        if (!model_err(p)) model_cur = model_code(p);
        for (int k = 0; k < 3; k++) step(6'b0, 1'b1);
        check_count++; if (cur_code !== 3'(model_cur)) $display("FAIL multi_cur got %0d want %0d", cur_code, model_cur); else pass_count++;
        $display("test_multihot cur=%0d", cur_code);
    endtask

    task automatic test_backpressure;
        for (int k = 0; k <= STABLE; k++) step(6'b000010, 1'b0);
        check_count++; if (out_valid !== 1'b1) $display("FAIL bp_valid_rise got %b want 1", out_valid); else pass_count++;
        for (int k = 0; k < 5; k++) begin
            step(6'b010000, 1'b0);
            check_count++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid k=%0d got %b want 1", k, out_valid); else pass_count++;
            check_count++; if (out_code !== 3'd5) $display("FAIL bp_hold_code k=%0d got %0d want 5", k, out_code); else pass_count++;
        end
        step(6'b010000, 1'b1);
        model_cur = 5;
        check_count++; if (out_valid !== 1'b0) $display("FAIL bp_drop got %b want 0", out_valid); else pass_count++;
        check_count++; if (cur_code !== 3'(model_cur)) $display("FAIL bp_cur got %0d want %0d", cur_code, model_cur); else pass_count++;
        for (int k = 0; k < 6; k++) begin
            step(6'b010000, 1'b1);
            check_count++; if (out_valid !== 1'b0 || busy !== 1'b1) $display("FAIL bp_release k=%0d got valid %b busy %b want 0 1", k, out_valid, busy); else pass_count++;
        end
        step(6'b0, 1'b1);
        check_count++; if (busy !== 1'b0) $display("FAIL bp_idle got busy %b want 0", busy); else pass_count++;
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 6; k++) step(6'b001000, 1'b0);
        check_count++; if (out_valid !== 1'b1) $display("FAIL rmid_present got %b want 1", out_valid); else pass_count++;
        reset_n = 1'b0;
        #1;
        model_cur = 0;
        check_count++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", out_valid); else pass_count++;
        check_count++; if (out_code !== 3'd0) $display("FAIL rmid_code got %0d want 0", out_code); else pass_count++;
        check_count++; if (out_err !== 1'b0) $display("FAIL rmid_err got %b want 0", out_err); else pass_count++;
        check_count++; if (cur_code !== 3'(model_cur)) $display("FAIL rmid_cur got %0d want 0", cur_code); else pass_count++;
        check_count++; if (busy !== 1'b1) $display("FAIL rmid_busy got %b want 1", busy); else pass_count++;
        step(6'b001000, 1'b1);
        step(6'b001000, 1'b1);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(6'b001000, 1'b1);
            check_count++; if (out_valid !== 1'b0) $display("FAIL rmid_held k=%0d got %b want 0", k, out_valid); else pass_count++;
        end
        step(6'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(6'b001000, 1'b1);
            check_count++;
            if (out_valid !== (k == STABLE)) $display("FAIL rmid_fresh_valid k=%0d got %b want %b", k, out_valid, (k == STABLE));
            else pass_count++;
            if (out_valid) begin
                check_count++; if (out_code !== 3'd3) $display("FAIL rmid_fresh_code got %0d want 3", out_code); else pass_count++;
            end
        end
        model_cur = 3;
        for (int k = 0; k < 3; k++) step(6'b0, 1'b1);
        check_count++; if (cur_code !== 3'(model_cur)) $display("FAIL rmid_fresh_cur got %0d want 3", cur_code); else pass_count++;
        $display("test_reset_mid done");
    endtask

    task automatic test_wide;
        logic [NW-1:0] p;
        int idx;
        for (int t = 0; t < 2; t++) begin
            idx = (t == 0) ? 0 : NW - 1;
            p   = NW'(1) << idx;
            for (int k = 0; k < 4; k++) begin
                step_w(p, 1'b1);
                check_count++;
                if (out_valid_w !== (k == 1)) $display("FAIL wide_valid bit=%0d k=%0d got %b want %b", idx, k, out_valid_w, (k == 1));
                else pass_count++;
                if (out_valid_w) begin
                    check_count++;
                    if (out_code_w !== 4'(NW - idx) || out_err_w !== 1'b0)
                        $display("FAIL wide_code bit=%0d got %0d err %b want %0d err 0", idx, out_code_w, out_err_w, NW - idx);
                    else pass_count++;
                end
            end
            for (int k = 0; k < 3; k++) step_w('0, 1'b1);
        end
        check_count++; if (cur_code_w !== 4'd1 || busy_w !== 1'b0) $display("FAIL wide_cur got %0d busy %b want 1 busy 0", cur_code_w, busy_w); else pass_count++;
        $display("test_wide done");
    endtask

    task automatic test_random;
        logic [N-1:0] p;
        logic         rdy;
        int           h;
        int           transfers;
        int           want;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 7) p = N'(1) << $urandom_range(0, N - 1);
            else                          p = N'($urandom_range(1, (1 << N) - 1));
            h         = $urandom_range(1, 10);
            want      = (h >= STABLE + 1) ? 1 : 0;
            transfers = 0;
            for (int k = 0; k < h + 3; k++) begin
                rdy = (k >= h) ? 1'b1 : ($urandom_range(0, 3) != 0);
                if (out_valid && rdy) begin
                    transfers++;
                    check_count++;
                    if (out_code !== 3'(model_code(p)) || out_err !== model_err(p))
                        $display("FAIL rand_xfer n=%0d pat=%b got %0d/%b want %0d/%b", n, p, out_code, out_err, model_code(p), model_err(p));
                    else pass_count++;
                end
                step((k < h) ? p : 6'b0, rdy);
            end
            if (want == 1 && !model_err(p)) model_cur = model_code(p);
            check_count++;
            if (transfers !== want) $display("FAIL rand_count n=%0d pat=%b hold=%0d got %0d want %0d", n, p, h, transfers, want);
            else pass_count++;
            check_count++;
            if (cur_code !== 3'(model_cur)) $display("FAIL rand_cur n=%0d got %0d want %0d", n, cur_code, model_cur);
            else pass_count++;
            $display("press n=%0d pat=%b hold=%0d transfers=%0d cur=%0d", n, p, h, transfers, cur_code);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        op_req      = '0;
        out_ready   = 1'b0;
        op_req_w    = '0;
        out_ready_w = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_multihot();
        test_backpressure();
        test_reset_mid();
        test_wide();
        test_random();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

endmodule
